// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic {OP_MUL, OP_DIV} op_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mplier_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] add_sel;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    sum      = {1'b0, acc_i} + {1'b0, mcand_i};
    add_sel  = mplier_i[0] ? sum : {1'b0, acc_i};
    // Remainder stays below the divisor magnitude (<= 2^(WIDTH-1)), so the
    // shifted remainder fits in WIDTH+1 bits and diff's MSB is the borrow.
    diff     = {acc_i, mplier_i[WIDTH-1]} - {1'b0, mcand_i};
    ge       = ~diff[WIDTH];
    acc_o    = '0;
    mplier_o = '0;
    if (op_i == OP_MUL) begin
      acc_o    = add_sel[WIDTH:1];
      mplier_o = {add_sel[0], mplier_i[WIDTH-1:1]};
    end else begin
      acc_o    = ge ? diff[WIDTH-1:0] : {acc_i[WIDTH-2:0], mplier_i[WIDTH-1]};
      mplier_o = {mplier_i[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed mult/div sequencer owning HI/LO, with EX-stage stall.
module muldiv_unit #(
  parameter int WIDTH = muldiv_pkg::WIDTH,
  parameter int ITER  = muldiv_pkg::ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             rd_hi,
  input  logic             rd_lo,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q
);
  import muldiv_pkg::*;

  localparam int CNT_BITS = $clog2(ITER + 1);

  state_t                state_q;
  op_t                   op_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [WIDTH-1:0]      acc_q, mcand_q, mplier_q, a_q;
  logic                  sign_a_q, sign_b_q, div0_q;
  logic [WIDTH-1:0]      acc_d, mplier_d;
  logic [WIDTH-1:0]      abs_a, abs_b;
  logic [2*WIDTH-1:0]    prod;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_i     (op_q),
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_d),
    .mplier_o (mplier_d)
  );

  // -2^(WIDTH-1) negates to itself, which is its correct unsigned magnitude.
  assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;
  assign prod  = {acc_q, mplier_q};

  assign busy    = (state_q != IDLE);
  assign stall   = busy & (start_mul | start_div | rd_hi | rd_lo);
  assign rd_data = rd_hi ? hi_q : lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      a_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_mul || start_div) begin
            op_q     <= start_mul ? OP_MUL : OP_DIV;
            sign_a_q <= op_a[WIDTH-1];
            sign_b_q <= op_b[WIDTH-1];
            div0_q   <= (op_b == '0);
            a_q      <= op_a;
            acc_q    <= '0;
            cnt_q    <= '0;
            mcand_q  <= start_mul ? abs_a : abs_b;
            mplier_q <= start_mul ? abs_b : abs_a;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_BITS'(ITER - 1)) state_q <= FIX;
        end
        FIX: begin
          if (op_q == OP_MUL) begin
            {hi_q, lo_q} <= (sign_a_q ^ sign_b_q) ? -prod : prod;
          end else if (div0_q) begin
            hi_q <= a_q;
            lo_q <= '1;
          end else begin
            lo_q <= (sign_a_q ^ sign_b_q) ? -mplier_q : mplier_q;
            hi_q <= sign_a_q ? -acc_q : acc_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: vector table plus stall/reset sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_mul = 1'b0, start_div = 1'b0, rd_hi = 1'b0, rd_lo = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, stall;
  logic [31:0] rd_data, hi_q, lo_q;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_mul (start_mul),
    .start_div (start_div),
    .rd_hi     (rd_hi),
    .rd_lo     (rd_lo),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .stall     (stall),
    .rd_data   (rd_data),
    .hi_q      (hi_q),
    .lo_q      (lo_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Counts cycles busy is observed high after the start edge; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    op_a      = a;
    op_b      = b;
    start_mul = ~is_div;
    start_div = is_div;
    @(posedge clk); #1;
    start_mul = 1'b0;
    start_div = 1'b0;
    wait_idle(n);
  endtask

  initial begin
    int n;
    int bad;

    vecs[0]  = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[4]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[5]  = '{1'b1, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[6]  = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7]  = '{1'b0, 32'h00012345, 32'h10,       32'd0,        32'h00123450};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[9]  = '{1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};
    vecs[11] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};

    // Reset state
    rd_lo = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_hi", 64'(hi_q), 64'd0);
    check("reset_lo", 64'(lo_q), 64'd0);
    rd_lo = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, n);
      check($sformatf("v%0d_busy_cycles", i), 64'(n), 64'd33);
      check($sformatf("v%0d_hi", i), 64'(hi_q), 64'(vecs[i].exp_hi));
      check($sformatf("v%0d_lo", i), 64'(lo_q), 64'(vecs[i].exp_lo));
      rd_hi = 1'b1; #1;
      check($sformatf("v%0d_rd_hi", i), 64'(rd_data), 64'(vecs[i].exp_hi));
      rd_hi = 1'b0; rd_lo = 1'b1; #1;
      check($sformatf("v%0d_rd_lo", i), 64'(rd_data), 64'(vecs[i].exp_lo));
      rd_lo = 1'b0;
    end

    // Reset in the middle of RUN discards the partial result
    op_a = 32'h1234; op_b = 32'h5678; start_mul = 1'b1;
    @(posedge clk); #1;
    start_mul = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rd_lo = 1'b1; #1;
    check("midrun_hi_unchanged", 64'(hi_q), 64'h3FFFFFFF);
    check("midrun_stall", 64'(stall), 64'd1);
    rst_n = 1'b0; #1;
    check("midrun_rst_busy", 64'(busy), 64'd0);
    check("midrun_rst_stall", 64'(stall), 64'd0);
    check("midrun_rst_hi", 64'(hi_q), 64'd0);
    check("midrun_rst_lo", 64'(lo_q), 64'd0);
    check("midrun_rst_rd", 64'(rd_data), 64'd0);
    rd_lo = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
    check("after_rst_cycles", 64'(n), 64'd33);
    check("after_rst_hi", 64'(hi_q), 64'd0);
    check("after_rst_lo", 64'(lo_q), 64'd1);

    // mflo one cycle after mult: stalled throughout busy, released with new LO
    op_a = 32'd3; op_b = 32'd4; start_mul = 1'b1;
    @(posedge clk); #1;
    start_mul = 1'b0;
    rd_lo = 1'b1;
    bad = 0; n = 0;
    while (busy && n < 200) begin
      if (!stall) bad++;
      n++;
      @(posedge clk); #1;
    end
    check("mflo_stall_cycles", 64'(n), 64'd33);
    check("mflo_stall_gaps", 64'(bad), 64'd0);
    check("mflo_stall_released", 64'(stall), 64'd0);
    check("mflo_rd_data", 64'(rd_data), 64'd12);
    rd_lo = 1'b0;

    // Second mult held while busy, accepted one edge after busy falls
    op_a = 32'd5; op_b = 32'd6; start_mul = 1'b1;
    @(posedge clk); #1;
    op_a = 32'hFFFFFFFE; op_b = 32'd9;
    bad = 0; n = 0;
    while (busy && n < 200) begin
      if (!stall) bad++;
      n++;
      @(posedge clk); #1;
    end
    check("held_stall_gaps", 64'(bad), 64'd0);
    check("held_first_lo", 64'(lo_q), 64'd30);
    check("held_first_hi", 64'(hi_q), 64'd0);
    check("held_idle_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check("held_accepted", 64'(busy), 64'd1);
    start_mul = 1'b0;
    wait_idle(n);
    check("held_second_cycles", 64'(n), 64'd33);
    check("held_second_hi", 64'(hi_q), 64'hFFFFFFFF);
    check("held_second_lo", 64'(lo_q), 64'hFFFFFFEE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
